// File: rtl/alarm_pkg.sv
// Shared types for the alarm controller: FSM state encoding, BCD digit type and counter sizing.
// Pure declarations; no logic, no latency, no flow control.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    localparam int BCD_W = 4;
    typedef logic [BCD_W-1:0] bcd_t;

    // Width that holds 0..n-1; a parameter of 1 still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Bundle between the clock core / front panel (master) and the alarm controller (slave).
// Level and BCD signals only; no handshake, the clock core never waits on the alarm.
interface alarm_controller_if;
    import alarm_pkg::*;

    logic tick_1Hz;
    logic alarm_en;
    logic set_alarm;
    logic stop_btn;
    logic snooze_btn;
    bcd_t hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s;
    bcd_t alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s;
    logic buzzer;
    logic alarm_led;
    logic ringing;
    logic snoozing;

    modport master (
        output tick_1Hz, alarm_en, set_alarm, stop_btn, snooze_btn,
        output hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s,
        output alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
        input  buzzer, alarm_led, ringing, snoozing
    );

    modport slave (
        input  tick_1Hz, alarm_en, set_alarm, stop_btn, snooze_btn,
        input  hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s,
        input  alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
        output buzzer, alarm_led, ringing, snoozing
    );

endinterface

// File: rtl/alarm_tone_gen.sv
// Square-wave tone divider; held at zero while disabled, first toggles TONE_HALF_PERIOD cycles after enable.
// Free-running while enabled; no backpressure.
module alarm_tone_gen
    import alarm_pkg::*;
#(
    parameter int TONE_HALF_PERIOD = 50000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic enable,
    output logic o_tone
);

    localparam int             TW        = cnt_w(TONE_HALF_PERIOD);
    localparam logic [TW-1:0]  HALF_LAST = TW'(TONE_HALF_PERIOD - 1);

    logic [TW-1:0] r_cnt;
    logic          r_tone;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (!enable) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (r_cnt == HALF_LAST) begin
            r_cnt  <= '0;
            r_tone <= ~r_tone;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_tone = r_tone;

endmodule

// File: rtl/alarm_controller.sv
// Alarm match detector with ring/snooze/stop FSM, gated buzzer tone and status LEDs.
// Events act 3 clk after the input edge (2-flop sync + edge detect); status flags lag state by 1 clk; no backpressure.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS     = 60,
    parameter int SNOOZE_SECONDS   = 300,
    parameter int MAX_SNOOZE       = 3,
    parameter int TONE_HALF_PERIOD = 50000
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    alarm_controller_if.slave  alarm
);

    localparam int            RW        = cnt_w(RING_SECONDS);
    localparam int            SW        = cnt_w(SNOOZE_SECONDS);
    localparam int            NW        = cnt_w(MAX_SNOOZE + 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECONDS - 1);
    localparam logic [NW-1:0] SNZ_MAX   = NW'(MAX_SNOOZE);

    // [1:0] synchronise, [2] holds the previous synchronised value for edge detection
    logic [2:0] r_tick_sh, r_stop_sh, r_snz_sh;
    logic       w_sec_p, w_stop_p, w_snz_p;
    logic       w_time_match, w_trigger;

    state_t        r_state, w_state_nxt;
    logic [RW-1:0] r_ring_ctr, w_ring_ctr_nxt;
    logic [SW-1:0] r_snz_ctr, w_snz_ctr_nxt;
    logic [NW-1:0] r_snooze_cnt, w_snooze_cnt_nxt;
    logic          r_beep_gate, w_beep_gate_nxt;

    logic w_ring_st, w_snz_st, w_tone, w_buzzer;
    logic r_ringing, r_snoozing, r_alarm_led;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_tick_sh <= '0;
            r_stop_sh <= '0;
            r_snz_sh  <= '0;
        end else begin
            r_tick_sh <= {r_tick_sh[1:0], alarm.tick_1Hz};
            r_stop_sh <= {r_stop_sh[1:0], alarm.stop_btn};
            r_snz_sh  <= {r_snz_sh[1:0],  alarm.snooze_btn};
        end
    end

    assign w_sec_p  = r_tick_sh[1] & ~r_tick_sh[2];
    assign w_stop_p = r_stop_sh[1] & ~r_stop_sh[2];
    assign w_snz_p  = r_snz_sh[1]  & ~r_snz_sh[2];

    // Digits are only looked at in the sec_p cycle, well after the clock core updated them.
    assign w_time_match = (alarm.hr_10s  == alarm.alarm_hr_10s)  &&
                          (alarm.hr_1s   == alarm.alarm_hr_1s)   &&
                          (alarm.min_10s == alarm.alarm_min_10s) &&
                          (alarm.min_1s  == alarm.alarm_min_1s)  &&
                          (alarm.sec_10s == '0) && (alarm.sec_1s == '0);
    assign w_trigger = w_sec_p && alarm.alarm_en && !alarm.set_alarm && w_time_match;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ring_ctr   <= '0;
            r_snz_ctr    <= '0;
            r_snooze_cnt <= '0;
            r_beep_gate  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ring_ctr   <= w_ring_ctr_nxt;
            r_snz_ctr    <= w_snz_ctr_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
            r_beep_gate  <= w_beep_gate_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ring_ctr_nxt   = r_ring_ctr;
        w_snz_ctr_nxt    = r_snz_ctr;
        w_snooze_cnt_nxt = r_snooze_cnt;
        w_beep_gate_nxt  = r_beep_gate;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state_nxt      = RINGING;
                    w_ring_ctr_nxt   = '0;
                    w_snooze_cnt_nxt = '0;
                    w_beep_gate_nxt  = 1'b1;
                end
            end
            RINGING: begin
                // Stop wins over snooze; an exhausted snooze falls through to the second handling.
                if (w_stop_p || !alarm.alarm_en) begin
                    w_state_nxt = IDLE;
                end else if (w_snz_p && (r_snooze_cnt < SNZ_MAX)) begin
                    w_state_nxt      = SNOOZE;
                    w_snz_ctr_nxt    = '0;
                    w_snooze_cnt_nxt = r_snooze_cnt + 1'b1;
                end else if (w_sec_p) begin
                    if (r_ring_ctr == RING_LAST) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_ring_ctr_nxt  = r_ring_ctr + 1'b1;
                        w_beep_gate_nxt = ~r_beep_gate;
                    end
                end
            end
            SNOOZE: begin
                if (w_stop_p || !alarm.alarm_en) begin
                    w_state_nxt = IDLE;
                end else if (w_sec_p) begin
                    if (r_snz_ctr == SNZ_LAST) begin
                        w_state_nxt     = RINGING;
                        w_ring_ctr_nxt  = '0;
                        w_beep_gate_nxt = 1'b1;
                    end else begin
                        w_snz_ctr_nxt = r_snz_ctr + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ring_st = (r_state == RINGING);
        w_snz_st  = (r_state == SNOOZE);
        w_buzzer  = w_tone & r_beep_gate & w_ring_st;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_ringing   <= 1'b0;
            r_snoozing  <= 1'b0;
            r_alarm_led <= 1'b0;
        end else begin
            r_ringing   <= w_ring_st;
            r_snoozing  <= w_snz_st;
            r_alarm_led <= w_ring_st | w_snz_st;
        end
    end

    alarm_tone_gen #(
        .TONE_HALF_PERIOD (TONE_HALF_PERIOD)
    ) u_tone (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .enable     (w_ring_st),
        .o_tone     (w_tone)
    );

    assign alarm.buzzer    = w_buzzer;
    assign alarm.ringing   = r_ringing;
    assign alarm.snoozing  = r_snoozing;
    assign alarm.alarm_led = r_alarm_led;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with shortened timing parameters and hand-computed expectations.
module tb_alarm_controller;
    import alarm_pkg::*;

    logic clk_100MHz = 1'b0;
    logic reset;

    always #5 clk_100MHz = ~clk_100MHz;

    alarm_controller_if u_if ();

    alarm_controller #(
        .RING_SECONDS     (4),
        .SNOOZE_SECONDS   (3),
        .MAX_SNOOZE       (1),
        .TONE_HALF_PERIOD (2)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .alarm      (u_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic status(input string tag, input logic ring, input logic snz, input logic led);
        check({tag, "_ringing"},  u_if.ringing,   ring);
        check({tag, "_snoozing"}, u_if.snoozing,  snz);
        check({tag, "_led"},      u_if.alarm_led, led);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        u_if.hr_10s  = 4'(h / 10);
        u_if.hr_1s   = 4'(h % 10);
        u_if.min_10s = 4'(m / 10);
        u_if.min_1s  = 4'(m % 10);
        u_if.sec_10s = 4'(s / 10);
        u_if.sec_1s  = 4'(s % 10);
    endtask

    // One second: new digits, tick high 4 clk, low 4 clk.
    task automatic tick_sec(input int h, input int m, input int s);
        @(negedge clk_100MHz);
        set_time(h, m, s);
        u_if.tick_1Hz = 1'b1;
        repeat (4) @(negedge clk_100MHz);
        u_if.tick_1Hz = 1'b0;
        repeat (4) @(negedge clk_100MHz);
    endtask

    task automatic press(input logic stop, input logic snz);
        @(negedge clk_100MHz);
        u_if.stop_btn   = stop;
        u_if.snooze_btn = snz;
        repeat (4) @(negedge clk_100MHz);
        u_if.stop_btn   = 1'b0;
        u_if.snooze_btn = 1'b0;
        repeat (4) @(negedge clk_100MHz);
    endtask

    task automatic buzz_window(output logic any);
        any = 1'b0;
        repeat (6) begin
            @(negedge clk_100MHz);
            any = any | u_if.buzzer;
        end
    endtask

    logic any_buzz;

    initial begin
        reset           = 1'b1;
        u_if.tick_1Hz   = 1'b0;
        u_if.alarm_en   = 1'b1;
        u_if.set_alarm  = 1'b0;
        u_if.stop_btn   = 1'b0;
        u_if.snooze_btn = 1'b0;
        u_if.alarm_hr_10s  = 4'd0;
        u_if.alarm_hr_1s   = 4'd7;
        u_if.alarm_min_10s = 4'd3;
        u_if.alarm_min_1s  = 4'd0;
        set_time(7, 29, 58);
        repeat (3) @(negedge clk_100MHz);
        status("reset", 1'b0, 1'b0, 1'b0);
        check("reset_buzzer", u_if.buzzer, 1'b0);
        reset = 1'b0;

        tick_sec(7, 29, 59);
        check("pre_match", u_if.ringing, 1'b0);

        // Trigger: state flips on the 3rd posedge after the tick, flag one edge later,
        // tone starts low and toggles every 2 clk.
        @(negedge clk_100MHz);
        set_time(7, 30, 0);
        u_if.tick_1Hz = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_100MHz);
            if (k == 6) u_if.tick_1Hz = 1'b0;
            if (k == 3) check("ring_lag", u_if.ringing, 1'b0);
            if (k == 4) check("ring_on", u_if.ringing, 1'b1);
            if (k >= 3) check($sformatf("tone_k%0d", k), u_if.buzzer, ((k - 3) >> 1) & 1);
        end
        check("ring_led", u_if.alarm_led, 1'b1);

        tick_sec(7, 30, 1);
        buzz_window(any_buzz);
        check("gate_off_s1", any_buzz, 1'b0);
        check("still_ring_s1", u_if.ringing, 1'b1);
        tick_sec(7, 30, 2);
        buzz_window(any_buzz);
        check("gate_on_s2", any_buzz, 1'b1);
        tick_sec(7, 30, 3);
        check("still_ring_s3", u_if.ringing, 1'b1);
        tick_sec(7, 30, 4);
        status("timeout", 1'b0, 1'b0, 1'b0);
        check("timeout_buzzer", u_if.buzzer, 1'b0);
        tick_sec(7, 30, 5);
        check("no_retrigger", u_if.ringing, 1'b0);

        // Snooze cycle
        tick_sec(7, 30, 0);
        check("trig2", u_if.ringing, 1'b1);
        press(1'b0, 1'b1);
        status("snooze", 1'b0, 1'b1, 1'b1);
        check("snooze_buzzer", u_if.buzzer, 1'b0);
        tick_sec(7, 30, 1);
        check("snz_s1", u_if.snoozing, 1'b1);
        tick_sec(7, 30, 2);
        check("snz_s2", u_if.snoozing, 1'b1);
        tick_sec(7, 30, 3);
        status("resume", 1'b1, 1'b0, 1'b1);
        press(1'b0, 1'b1);
        status("snz_exhausted", 1'b1, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        status("stopped", 1'b0, 1'b0, 1'b0);
        check("stopped_buzzer", u_if.buzzer, 1'b0);

        // Stop and snooze together
        tick_sec(7, 30, 0);
        check("trig3", u_if.ringing, 1'b1);
        press(1'b1, 1'b1);
        status("stop_beats_snz", 1'b0, 1'b0, 1'b0);

        // Suppressed or non-matching triggers
        u_if.set_alarm = 1'b1;
        tick_sec(7, 30, 0);
        check("set_alarm_block", u_if.ringing, 1'b0);
        u_if.set_alarm = 1'b0;
        u_if.alarm_en  = 1'b0;
        tick_sec(7, 30, 0);
        check("disabled_block", u_if.ringing, 1'b0);
        u_if.alarm_en  = 1'b1;
        tick_sec(7, 31, 0);
        check("min_mismatch", u_if.ringing, 1'b0);
        tick_sec(8, 30, 0);
        check("hr_mismatch", u_if.ringing, 1'b0);
        tick_sec(7, 30, 10);
        check("sec10_nonzero", u_if.ringing, 1'b0);

        // alarm_en dropped while snoozing
        tick_sec(7, 30, 0);
        press(1'b0, 1'b1);
        check("snz_again", u_if.snoozing, 1'b1);
        @(negedge clk_100MHz);
        u_if.alarm_en = 1'b0;
        @(negedge clk_100MHz);
        check("en_drop_lag", u_if.snoozing, 1'b1);
        @(negedge clk_100MHz);
        status("en_drop", 1'b0, 1'b0, 1'b0);
        u_if.alarm_en = 1'b1;

        // Asynchronous reset mid-ring
        tick_sec(7, 30, 0);
        check("trig_pre_reset", u_if.ringing, 1'b1);
        @(negedge clk_100MHz);
        reset = 1'b1;
        #1;
        status("async_reset", 1'b0, 1'b0, 1'b0);
        check("async_reset_buzzer", u_if.buzzer, 1'b0);
        @(negedge clk_100MHz);
        reset = 1'b0;
        tick_sec(7, 30, 1);
        check("post_reset_idle", u_if.ringing, 1'b0);
        tick_sec(7, 30, 0);
        check("post_reset_trig", u_if.ringing, 1'b1);
        press(1'b1, 1'b0);
        check("post_reset_stop", u_if.ringing, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Sits directly downstream of the binary/BCD clock core and consumes its BCD time digits, its alarm-setting digits and its 1 Hz tick.
- Detects when the alarm time is reached and runs a ring / snooze / stop state machine.
- Drives a gated tone for the Basys3 buzzer pin and status LEDs.
- Reset and clock are shared with the clock core.

Parameters:
- RING_SECONDS, 60: seconds of ringing before auto-stop.
- SNOOZE_SECONDS, 300: snooze length in seconds.
- MAX_SNOOZE, 3: number of snoozes allowed per alarm event.
- TONE_HALF_PERIOD, 50000: clk cycles per tone half-period (1 kHz at 100 MHz).

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick_1Hz  in  1  1 Hz square wave from the clock core; its rising edge marks a new second.
- alarm_en  in  1  alarm armed (slide switch, level).
- set_alarm  in  1  alarm-edit mode active; suppresses triggering.
- stop_btn  in  1  raw pushbutton; stops the alarm.
- snooze_btn  in  1  raw pushbutton; requests snooze.
- hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s  in  4 each  current time, BCD.
- alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s  in  4 each  alarm time, BCD.
- buzzer  out  1  tone output.
- alarm_led  out  1  high while ringing or snoozing.
- ringing  out  1  state == RINGING.
- snoozing  out  1  state == SNOOZE.

Behaviour:
- Reset (async, active-high): state=IDLE, all counters 0, all outputs 0, beep_gate=0.
- Input synchronisation:
  - tick_1Hz, stop_btn and snooze_btn each pass through a 2-flop synchroniser.
  - A rising-edge detector follows each synchroniser, giving one-cycle pulses sec_p, stop_p, snz_p.
  - tick_1Hz must stay high at least 3 clk cycles.
- Digit sampling: time digits are read only in the cycle sec_p is asserted. That cycle is at least 2 cycles after the tick edge, so the digits have settled.
- Trigger: sec_p && alarm_en && !set_alarm && hr/min digits equal the alarm digits && sec_10s==0 && sec_1s==0.
- IDLE:
  - On trigger: go to RINGING; ring_ctr=0, snooze_cnt=0, beep_gate=1.
- RINGING (exits checked in priority order):
  1. stop_p or !alarm_en: go to IDLE.
  2. snz_p with snooze_cnt<MAX_SNOOZE: go to SNOOZE; snz_ctr=0, snooze_cnt+1.
  3. snz_p with snooze_cnt==MAX_SNOOZE: ignored.
  4. sec_p with ring_ctr==RING_SECONDS-1: go to IDLE (auto-timeout).
  5. Otherwise on sec_p: ring_ctr+1 and beep_gate toggles.
- SNOOZE:
  - stop_p or !alarm_en: go to IDLE.
  - sec_p with snz_ctr==SNOOZE_SECONDS-1: go to RINGING; ring_ctr=0, beep_gate=1.
  - Otherwise on sec_p: snz_ctr+1.
  - snz_p is ignored.
- Simultaneous events:
  - stop beats snooze, snooze beats timeout.
  - A trigger arriving while in RINGING or SNOOZE is ignored.
- Outputs:
  - buzzer = tone & beep_gate while RINGING, else 0.
  - The tone divider is held at 0 and tone=0 whenever the state is not RINGING. Each ring therefore starts with the tone low and first toggles after TONE_HALF_PERIOD cycles.
  - ringing, snoozing and alarm_led are registered and update one cycle after the state change.
- No retrigger within the same minute after stop: the next sec_p carries sec=01, so the trigger condition fails.
- Reset mid-ring returns to IDLE immediately (asynchronous).
- Counter widths: clog2 of each parameter. There is no BCD arithmetic; only equality compares on the digits.

Decomposition:
- Package alarm_pkg:
  - state encoding IDLE=2'd0, RINGING=2'd1, SNOOZE=2'd2.
  - BCD digit width constant (4).
- One sub-module, alarm_tone_gen:
  - inputs: clk_100MHz, reset, enable.
  - parameter TONE_HALF_PERIOD.
  - output: square wave.
- Synchronisers and edge detectors stay inline.

Test Plan (parameters overridden to RING_SECONDS=4, SNOOZE_SECONDS=3, MAX_SNOOZE=1, TONE_HALF_PERIOD=2):
- Alarm 07:30 set, alarm_en=1, time steps 07:29:59 -> 07:30:00 on tick -> ringing=1 within 3 clk of sec_p; buzzer toggles every 2 clk while beep_gate=1; beep_gate alternates each later second.
- Ring with no buttons -> after the 4th subsequent sec_p the state is IDLE and buzzer=0. Time 07:30:04 onward gives no retrigger.
- Trigger, snz_p -> snoozing=1, buzzer=0; after 3 sec_p ringing=1 again. Second snz_p ignored (MAX_SNOOZE=1); stop_p -> IDLE.
- stop_p and snz_p in the same cycle while RINGING -> IDLE, snooze count unused.
- set_alarm=1 or alarm_en=0 at 07:30:00 -> no trigger. alarm_en dropped during SNOOZE -> IDLE next cycle.
- reset pulse mid-RINGING -> all outputs 0 immediately; after release the block stays IDLE until the next 00-second match.
